simd_block_scheduler: RTL and testbench
=======================================

Name: simd_block_scheduler

Overview:
- Sequences a kernel launch across the SIMD lanes.
- Splits a thread count into blocks of NUM_LANES threads and drives the lanes' thread-enable mask and block index for each block.
- Issues one launch per block, waits for the lanes to report block completion, then advances.
- Sits between the top-level control/host interface and the lanes datapath; also counts kernel cycles for performance reporting.

Parameters:
- NUM_LANES, 4: threads per block; width of the thread mask. Power of two, ≥2.
- CNT_W, 32: width of the thread-count, block-index and cycle-counter registers.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  kernel launch request; sampled only in IDLE
- total_threads  in  CNT_W  thread count for the kernel; sampled with start
- stall  in  1  pipeline stall; holds a pending launch
- block_done  in  1  single-cycle pulse from the lanes: current block has retired
- launch  out  1  block-issue strobe to the lanes
- threads  out  NUM_LANES  per-lane thread enable for the current block
- bIdx  out  CNT_W  current block index
- busy  out  1  kernel in progress
- done  out  1  single-cycle kernel-complete pulse
- kernel_cycles  out  CNT_W  cycle count of the last or current kernel

Behaviour:
- Reset (asynchronous, any state): state=IDLE; launch=0, threads=0, bIdx=0, busy=0, done=0, kernel_cycles=0; remaining=0.
- States: IDLE, LAUNCH, RUN, FINISH.
- IDLE:
  - start=1 and total_threads>0: remaining<=total_threads, bIdx<=0, kernel_cycles<=1, next=LAUNCH.
  - start=1 and total_threads=0: kernel_cycles<=1, next=FINISH; no launch is ever issued.
- LAUNCH:
  - launch=1 combinationally while in LAUNCH.
  - stall=1: stay; launch, threads and bIdx are held stable.
  - stall=0: issue accepted, next=RUN.
  - block_done is ignored in this state.
- RUN:
  - Wait for block_done.
  - On block_done with remaining≤NUM_LANES: next=FINISH.
  - On block_done otherwise: remaining-=NUM_LANES, bIdx+=1, next=LAUNCH.
  - stall has no effect in RUN.
- FINISH: done=1 for exactly one cycle, then next=IDLE. threads<=0 on exit.
- threads mask:
  - LAUNCH/RUN: remaining≥NUM_LANES gives all ones; otherwise (1<<remaining)-1 (low lanes enabled).
  - IDLE/FINISH: 0.
- busy=1 in LAUNCH, RUN and FINISH.
- kernel_cycles:
  - Increments by 1 every cycle in LAUNCH and RUN; FINISH is included in the count.
  - Holds its value in IDLE until the next accepted start.
  - Saturates at all ones; no wrap.
- start while busy=1 is ignored; total_threads is not resampled.
- block_done outside RUN is ignored.
- Launch-to-launch spacing is at least 2 cycles (LAUNCH→RUN→LAUNCH).
- Arithmetic: remaining and bIdx are unsigned CNT_W. Block count = ceil(total_threads/NUM_LANES). bIdx never exceeds block count-1.
- A reset asserted in any state aborts the kernel; no done pulse is produced for it.

Decomposition:
- simd_pkg holds:
  - sched_state_t enum {IDLE, LAUNCH, RUN, FINISH}
  - NUM_LANES_DEFAULT constant
  - function lane_mask(remaining) returning the NUM_LANES-bit enable mask
- No sub-module; the block is a single FSM with counters.

Test Plan:
- total_threads=10, NUM_LANES=4, block_done 3 cycles after each launch, stall=0 -> three launch pulses with (bIdx, threads) = (0, 1111), (1, 1111), (2, 0011); then one done pulse; busy falls the cycle after done.
- total_threads=4 -> exactly one launch with bIdx=0, threads=1111; done follows the first block_done; kernel_cycles=block latency+3.
- total_threads=0 -> no launch; done asserted the cycle after start; kernel_cycles=1.
- stall=1 for 5 cycles during the second LAUNCH of a total=8 kernel -> launch held high for 6 cycles with bIdx=1, threads=1111 stable; RUN entered on the first cycle with stall=0.
- start pulsed during RUN with total_threads=100, and block_done pulsed during LAUNCH -> both ignored; original block sequence and bIdx unchanged.
- rst asserted mid-RUN at bIdx=1 -> all outputs 0 asynchronously, no done pulse; a new start with total=3 afterwards runs one block with threads=0111.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types and helpers for the SIMD block scheduler.
// The lane-mask helper is sized for the widest supported lane count; callers take the low bits.
package simd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        FINISH
    } sched_state_t;

    localparam int unsigned NUM_LANES_DEFAULT = 4;
    localparam int unsigned MAX_LANES         = 64;

    // Enables the low min(remaining, lanes) lanes.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [63:0] remaining,
                                                       input int unsigned lanes);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < lanes && 64'(i) < remaining) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/simd_block_scheduler.sv
// Splits a kernel's thread count into NUM_LANES-wide blocks, issues one launch per block and
// waits for each block to retire; also counts kernel cycles (saturating).
module simd_block_scheduler
    import simd_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEFAULT,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     total_threads,
    input  logic                 stall,
    input  logic                 block_done,
    output logic                 launch,
    output logic [NUM_LANES-1:0] threads,
    output logic [CNT_W-1:0]     bIdx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     kernel_cycles
);

    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(NUM_LANES);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] bidx_q, bidx_d;
    logic [CNT_W-1:0] kcycles_q, kcycles_d;

    logic [MAX_LANES-1:0] full_mask;
    logic                 unused_mask_bits;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bidx_d      = bidx_q;
        kcycles_d   = kcycles_q;

        // Every non-idle cycle, FINISH included, counts toward the kernel.
        if (state_q != IDLE && kcycles_q != '1) begin
            kcycles_d = kcycles_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    kcycles_d = CNT_W'(1);
                    if (total_threads != '0) begin
                        remaining_d = total_threads;
                        bidx_d      = '0;
                        state_d     = LAUNCH;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            LAUNCH: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (block_done) begin
                    if (remaining_q <= LANES_C) begin
                        state_d = FINISH;
                    end else begin
                        remaining_d = remaining_q - LANES_C;
                        bidx_d      = bidx_q + CNT_W'(1);
                        state_d     = LAUNCH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            bidx_q      <= '0;
            kcycles_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bidx_q      <= bidx_d;
            kcycles_q   <= kcycles_d;
        end
    end

    assign full_mask        = lane_mask(64'(remaining_q), NUM_LANES);
    assign unused_mask_bits = ^full_mask[MAX_LANES-1:NUM_LANES];

    assign launch        = (state_q == LAUNCH);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FINISH);
    assign bIdx          = bidx_q;
    assign kernel_cycles = kcycles_q;
    assign threads       = (state_q == LAUNCH || state_q == RUN) ? full_mask[NUM_LANES-1:0] : '0;

endmodule

// File: tb/tb_simd_block_scheduler.sv
// Directed bench for simd_block_scheduler with a transaction-level model checked every cycle.
module tb_simd_block_scheduler;

    localparam int NL = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] total_threads = '0;
    logic          stall = 1'b0;
    logic          block_done = 1'b0;
    logic          launch;
    logic [NL-1:0] threads;
    logic [CW-1:0] bIdx;
    logic          busy;
    logic          done;
    logic [CW-1:0] kernel_cycles;

    simd_block_scheduler #(
        .NUM_LANES(NL),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .total_threads(total_threads),
        .stall        (stall),
        .block_done   (block_done),
        .launch       (launch),
        .threads      (threads),
        .bIdx         (bIdx),
        .busy         (busy),
        .done         (done),
        .kernel_cycles(kernel_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Model: kernel-level bookkeeping of blocks issued and retired.
    bit            m_active, m_finish, m_out;
    int            m_nb, m_acc;
    longint        m_total;
    logic [CW-1:0] m_kc;

    logic [CW-1:0] log_bidx[$];
    logic [NL-1:0] log_thr[$];
    int            launch_b1;
    bit            spurious;

    function automatic logic [NL-1:0] exp_mask(input longint total, input int blk);
        logic [NL-1:0] m;
        longint        rem;
        m   = '0;
        rem = total - longint'(NL) * blk;
        for (int i = 0; i < NL; i++) begin
            if (longint'(i) < rem) m[i] = 1'b1;
        end
        return m;
    endfunction

    always @(negedge clk) begin
        bit pend;
        if (rst) begin
            chk("rst_launch", launch, 0);
            chk("rst_threads", threads, 0);
            chk("rst_bidx", bIdx, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_kcycles", kernel_cycles, 0);
            m_active = 0; m_finish = 0; m_out = 0;
            m_nb = 0; m_acc = 0; m_total = 0; m_kc = '0;
        end else begin
            pend = m_active && !m_finish && !m_out && (m_acc < m_nb);
            chk("busy", busy, m_active);
            chk("done", done, m_finish);
            chk("launch", launch, pend);
            chk("kcycles", kernel_cycles, m_kc);
            if (pend) begin
                chk("bidx_launch", bIdx, m_acc);
                chk("threads_launch", threads, exp_mask(m_total, m_acc));
            end else if (m_out) begin
                chk("bidx_run", bIdx, m_acc - 1);
                chk("threads_run", threads, exp_mask(m_total, m_acc - 1));
            end else begin
                chk("threads_idle", threads, 0);
                if (m_finish && m_nb > 0) chk("bidx_finish", bIdx, m_nb - 1);
            end

            if (launch && bIdx == 1) launch_b1++;
            if (launch && !stall) begin
                log_bidx.push_back(bIdx);
                log_thr.push_back(threads);
            end

            if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_total  = longint'(total_threads);
                    m_nb     = int'((m_total + NL - 1) / NL);
                    m_acc    = 0;
                    m_out    = 0;
                    m_kc     = 1;
                    m_finish = (m_nb == 0);
                end
            end else begin
                if (m_kc != '1) m_kc = m_kc + 1;
                if (m_finish) begin
                    m_active = 0;
                    m_finish = 0;
                end else if (pend && !stall) begin
                    m_acc++;
                    m_out = 1;
                end else if (m_out && block_done) begin
                    m_out = 0;
                    if (m_acc == m_nb) m_finish = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_bidx.delete();
        log_thr.delete();
        launch_b1 = 0;
    endtask

    // Runs one kernel, answering each launch with block_done lat cycles later.
    task automatic run_kernel(input int total, input int lat, input int stall_blk,
                              input int stall_n, input int abort_blk);
        int  cd;
        int  sc;
        int  guard;
        bit  aborted;
        cd = 0; sc = 0; guard = 0; aborted = 0;
        start = 1'b1;
        total_threads = CW'(total);
        step();
        start = 1'b0;
        while (guard < 500) begin
            block_done = 1'b0;
            stall      = 1'b0;
            start      = 1'b0;
            if (done) break;
            if (abort_blk >= 0 && cd > 0 && bIdx == CW'(abort_blk)) begin
                aborted = 1;
                break;
            end
            if (launch) begin
                if (bIdx == CW'(stall_blk) && sc < stall_n) begin
                    stall = 1'b1;
                    sc++;
                end else begin
                    cd = lat;
                end
                if (spurious && bIdx == 1) block_done = 1'b1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) block_done = 1'b1;
                if (spurious && cd == 2) begin
                    start = 1'b1;
                    total_threads = CW'(100);
                end
            end
            step();
            guard++;
        end
        if (!aborted) begin
            if (guard >= 500) chk("kernel_timeout", 0, 1);
            step();
        end
    endtask

    initial begin
        spurious = 0;
        launch_b1 = 0;
        @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_kcycles", kernel_cycles, 0);
        step();
        rst = 1'b0;
        step();

        // 10 threads: blocks (0,1111) (1,1111) (2,0011)
        clear_logs();
        run_kernel(10, 3, -1, 0, -1);
        chk("t10_busy_after_done", busy, 0);
        chk("t10_kcycles", kernel_cycles, 14);
        chk("t10_launches", log_bidx.size(), 3);
        if (log_bidx.size() == 3) begin
            chk("t10_b0", {log_bidx[0], 28'd0, log_thr[0]}, {32'd0, 32'hF});
            chk("t10_b1", {log_bidx[1], 28'd0, log_thr[1]}, {32'd1, 32'hF});
            chk("t10_b2", {log_bidx[2], 28'd0, log_thr[2]}, {32'd2, 32'h3});
        end

        // 4 threads: one full block
        clear_logs();
        run_kernel(4, 3, -1, 0, -1);
        chk("t4_kcycles", kernel_cycles, 6);
        chk("t4_launches", log_bidx.size(), 1);
        if (log_bidx.size() == 1) chk("t4_b0", {log_bidx[0], 28'd0, log_thr[0]}, {32'd0, 32'hF});

        // 0 threads: no launch, done right after start
        clear_logs();
        start = 1'b1;
        total_threads = '0;
        step();
        start = 1'b0;
        chk("t0_done", done, 1);
        chk("t0_kcycles", kernel_cycles, 1);
        chk("t0_launch", launch, 0);
        step();
        chk("t0_busy_after", busy, 0);
        chk("t0_launches", log_bidx.size(), 0);

        // 8 threads, second launch stalled 5 cycles
        clear_logs();
        run_kernel(8, 3, 1, 5, -1);
        chk("stall_launch_b1_cycles", launch_b1, 6);
        chk("stall_kcycles", kernel_cycles, 15);
        chk("stall_launches", log_bidx.size(), 2);
        if (log_bidx.size() == 2) chk("stall_b1", {log_bidx[1], 28'd0, log_thr[1]}, {32'd1, 32'hF});

        // Start during RUN and block_done during LAUNCH are ignored
        clear_logs();
        spurious = 1;
        run_kernel(10, 3, -1, 0, -1);
        spurious = 0;
        chk("spur_kcycles", kernel_cycles, 14);
        chk("spur_launches", log_bidx.size(), 3);
        if (log_bidx.size() == 3) chk("spur_b2", {log_bidx[2], 28'd0, log_thr[2]}, {32'd2, 32'h3});
        chk("spur_busy_after", busy, 0);

        // Reset mid-RUN at block 1
        clear_logs();
        run_kernel(8, 3, -1, 0, 1);
        chk("abort_in_run_bidx", bIdx, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_launch", launch, 0);
        chk("abort_threads", threads, 0);
        chk("abort_bidx", bIdx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_kcycles", kernel_cycles, 0);
        @(negedge clk);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_done", done, 0);
        clear_logs();
        run_kernel(3, 2, -1, 0, -1);
        chk("t3_launches", log_bidx.size(), 1);
        if (log_bidx.size() == 1) chk("t3_b0", {log_bidx[0], 28'd0, log_thr[0]}, {32'd0, 32'h7});
        chk("t3_kcycles", kernel_cycles, 5);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
